// File: rtl/dct_quantizer.sv
// Quantizer between the Loeffler DCT and zig-zag stage: scales each coefficient by a
// per-position reciprocal, rounds half away from zero, saturates to +/-(2^(OUT_WIDTH-1)-1).
module dct_quantizer #(
  parameter int COEF_WIDTH  = 12,
  parameter int RECIP_WIDTH = 16,
  parameter int OUT_WIDTH   = 11
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [COEF_WIDTH-1:0]  in_coef,
  input  logic                          qtab_we,
  input  logic [5:0]                    qtab_addr,
  input  logic [RECIP_WIDTH-1:0]        qtab_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [5:0]                    out_index,
  output logic                          out_last
);

  localparam int PROD_W = COEF_WIDTH + RECIP_WIDTH;
  localparam int Q_W    = PROD_W - 14;
  localparam logic [Q_W-1:0]    Q_MAX = Q_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic [PROD_W:0]   HALF  = (PROD_W + 1)'(1) << 14;

  function automatic logic [Q_W-1:0] round_q(input logic [PROD_W-1:0] p);
    logic [PROD_W:0] s;
    s = {1'b0, p} + HALF;
    return s[PROD_W:15];
  endfunction

  // Clamping the magnitude before negation keeps the range symmetric and avoids -0.
  function automatic logic signed [OUT_WIDTH-1:0] sat_sign(input logic [Q_W-1:0] q,
                                                           input logic neg);
    logic [OUT_WIDTH-1:0] m;
    if (q > Q_MAX) m = Q_MAX[OUT_WIDTH-1:0];
    else           m = q[OUT_WIDTH-1:0];
    return neg ? -signed'(m) : signed'(m);
  endfunction

  logic [RECIP_WIDTH-1:0] qtab [64];
  logic [5:0]             cnt;
  logic                   stall;
  logic [COEF_WIDTH-1:0]  mag_c;

  logic                   vld_p0, vld_p1, vld_p2;
  logic                   neg_p0, neg_p1, neg_p2;
  logic [5:0]             idx_p0, idx_p1, idx_p2;
  logic [COEF_WIDTH-1:0]  mag_p0;
  logic [RECIP_WIDTH-1:0] recip_p0;
  logic [PROD_W-1:0]      prod_p1;
  logic [Q_W-1:0]         q_p2;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    mag_c = in_coef[COEF_WIDTH-1] ? unsigned'(-in_coef) : unsigned'(in_coef);
  end

  // Table writes ignore stall; a same-cycle read below sees the old entry.
  always_ff @(posedge clock) begin
    if (qtab_we) qtab[qtab_addr] <= qtab_wdata;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      cnt       <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      if (in_valid) cnt <= cnt + 6'd1;
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      // Output stage: clamp and restore sign
      out_data  <= sat_sign(q_p2, neg_p2);
      out_index <= idx_p2;
      out_last  <= vld_p2 && (idx_p2 == 6'd63);
    end
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      // S1: sign/magnitude split, synchronous table read
      neg_p0   <= in_coef[COEF_WIDTH-1];
      mag_p0   <= mag_c;
      idx_p0   <= cnt;
      recip_p0 <= qtab[cnt];
      // S2: unsigned scale
      neg_p1   <= neg_p0;
      idx_p1   <= idx_p0;
      prod_p1  <= PROD_W'(mag_p0) * PROD_W'(recip_p0);
      // S3: round half away from zero on the magnitude
      neg_p2   <= neg_p1;
      idx_p2   <= idx_p1;
      q_p2     <= round_q(prod_p1);
    end
  end

endmodule

// File: tb/tb_dct_quantizer.sv
// Scoreboard bench for dct_quantizer: stimulus pushes expected outputs, a monitor pops
// and compares them on every output transfer.
module tb_dct_quantizer;

  localparam int COEF_WIDTH  = 12;
  localparam int RECIP_WIDTH = 16;
  localparam int OUT_WIDTH   = 11;

  logic                         clock;
  logic                         nreset;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [COEF_WIDTH-1:0] in_coef;
  logic                         qtab_we;
  logic [5:0]                   qtab_addr;
  logic [RECIP_WIDTH-1:0]       qtab_wdata;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic [5:0]                   out_index;
  logic                         out_last;

  dct_quantizer #(
    .COEF_WIDTH (COEF_WIDTH),
    .RECIP_WIDTH(RECIP_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .clock     (clock),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .qtab_we   (qtab_we),
    .qtab_addr (qtab_addr),
    .qtab_wdata(qtab_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  typedef struct {
    int d;
    int idx;
    int last;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_idx = 0;
  bit   lat_chk = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, once stimulus has settled.
  initial begin
    bit   held = 0;
    int   hd = 0, hi = 0, hl = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!nreset) begin
        held = 0;
      end else begin
        if (held) begin
          chk("stall_valid_hold", int'(out_valid), 1);
          chk("stall_data_hold", int'(out_data), hd);
          chk("stall_index_hold", int'(out_index), hi);
          chk("stall_last_hold", int'(out_last), hl);
        end
        chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), e.d);
            chk("out_index", int'(out_index), e.idx);
            chk("out_last", int'(out_last), e.last);
            if (e.lat) chk("latency", cyc - e.acc, 3);
          end
        end
        held = out_valid && !out_ready;
        hd = int'(out_data);
        hi = int'(out_index);
        hl = int'(out_last);
      end
    end
  end

  // One clock of stimulus, called just after a falling edge.
  task automatic cycle(input logic v, input int c, input logic ordy, input int exp_d,
                       output logic acc);
    exp_t e;
    in_valid  = v;
    in_coef   = c[COEF_WIDTH-1:0];
    out_ready = ordy;
    #1;
    acc = v && in_ready && nreset;
    if (acc) begin
      e.d    = exp_d;
      e.idx  = exp_idx;
      e.last = (exp_idx == 63) ? 1 : 0;
      e.acc  = cyc + 1;
      e.lat  = lat_chk;
      sb.push_back(e);
      exp_idx = (exp_idx + 1) % 64;
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input logic drop_valid);
    nreset    = 1'b0;
    in_valid  = drop_valid;
    in_coef   = 12'sd999;
    out_ready = 1'b0;
    sb.delete();
    exp_idx   = 0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    nreset    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic load_table(input int mode);
    for (int k = 0; k < 64; k++) begin
      qtab_we    = 1'b1;
      qtab_addr  = 6'(k);
      qtab_wdata = (mode == 0) ? 16'd32768 :
                   (mode == 1) ? 16'd2048  : 16'(32768 >> (k % 4));
      @(negedge clock);
    end
    qtab_we = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int j = 0; j < 60 && sb.size() != 0; j++) cycle(1'b0, 0, 1'b1, 0, acc);
    for (int j = 0; j < 4; j++) cycle(1'b0, 0, 1'b1, 0, acc);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic send_list(input int n, input int coefs[8], input int exps[8]);
    logic acc;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, coefs[i], 1'b1, exps[i], acc);
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    int   i, j;
    int   cv[8];
    int   ev[8];
    nreset = 1'b0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
    qtab_we = 1'b0; qtab_addr = '0; qtab_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    do_reset(1'b0);

    // Pass-through with Q=1, including latency
    load_table(0);
    lat_chk = 1;
    cv = '{100, -5, 0, 0, 0, 0, 0, 0};
    ev = '{100, -5, 0, 0, 0, 0, 0, 0};
    send_list(3, cv, ev);
    drain();
    lat_chk = 0;

    // Saturation, Q=1
    cv = '{2047, -2048, 1023, -1, 0, 0, 0, 0};
    ev = '{1023, -1023, 1023, -1, 0, 0, 0, 0};
    send_list(4, cv, ev);
    drain();

    // Rounding, Q=16
    do_reset(1'b0);
    load_table(1);
    cv = '{24, -24, 23, -8, 7, -7, 0, 0};
    ev = '{2, -2, 1, -1, 0, 0, 0, 0};
    send_list(6, cv, ev);
    drain();

    // Position counter and wrap
    do_reset(1'b0);
    load_table(2);
    for (int n = 0; n < 130; n++) begin
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, 64, 1'b1, 64 >> (exp_idx % 4), acc);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: 5-cycle stall, then alternating ready
    do_reset(1'b0);
    load_table(0);
    i = 0;
    j = 0;
    while (i < 20 && j < 200) begin
      cycle(1'b1, i * 50 - 400,
            (j >= 6 && j <= 10) ? 1'b0 : (j >= 16) ? logic'(j % 2) : 1'b1,
            i * 50 - 400, acc);
      if (acc) i++;
      j++;
    end
    chk("bp_all_accepted", i, 20);
    in_valid = 1'b0;
    drain();

    // Reset mid-block: in-flight data dropped, index restarts, table retained
    do_reset(1'b0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 10 + n, 1'b1, 10 + n, acc);
    do_reset(1'b1);
    cv = '{300, -301, 5, 0, 0, 0, 0, 0};
    ev = '{300, -301, 5, 0, 0, 0, 0, 0};
    send_list(3, cv, ev);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual %0d required 0", 1);
    $fatal(1, "timeout");
  end

endmodule
